// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller: coin credit, priced selection, dispense, then change.
// Optional refund path is compiled in when VEND_CANCEL_EN is defined.
module vending_ctrl_multi #(
    parameter int AMT_W      = 8,
    parameter int N_PROD     = 4,
    parameter int SEL_W      = 2,
    parameter int MAX_CREDIT = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c,
    input  logic [AMT_W-1:0]        a,
    input  logic [N_PROD*AMT_W-1:0] s,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    sel_vld,
    input  logic                    cancel,
    output logic [AMT_W-1:0]        credit,
    output logic                    busy,
    output logic                    coin_rej,
    output logic                    nsf,
    output logic                    d,
    output logic [SEL_W-1:0]        d_prod,
    output logic [AMT_W-1:0]        chg,
    output logic                    chg_vld,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_CHG  = 2'd2
    } state_t;

    localparam logic [AMT_W:0] MAX_W = (AMT_W+1)'(MAX_CREDIT);

    state_t             r_state, w_state;
    logic [AMT_W-1:0]   r_credit, w_credit;
    logic [AMT_W-1:0]   r_change, w_change;
    logic               r_coin_rej, w_coin_rej;
    logic               r_nsf, w_nsf;
    logic               r_d, w_d;
    logic [SEL_W-1:0]   r_d_prod, w_d_prod;
    logic [AMT_W-1:0]   r_chg, w_chg;
    logic               r_chg_vld, w_chg_vld;

    logic [AMT_W-1:0]   w_price;
    logic               w_sel_ok;
    logic [AMT_W:0]     w_sum;
    logic               w_cancel;

    // Out-of-range selects read as price 0 but are refused through w_sel_ok.
    always_comb begin
        w_price = '0;
        for (int k = 0; k < N_PROD; k++) begin
            if (32'(sel) == k) w_price = s[k*AMT_W +: AMT_W];
        end
    end

    assign w_sel_ok = (32'(sel) < N_PROD);
    assign w_sum    = {1'b0, r_credit} + {1'b0, a};

`ifdef VEND_CANCEL_EN
    assign w_cancel = cancel && (r_credit != '0);
`else
    assign w_cancel = cancel & 1'b0;
`endif

    always_comb begin
        w_state    = r_state;
        w_credit   = r_credit;
        w_change   = r_change;
        w_coin_rej = 1'b0;
        w_nsf      = 1'b0;
        w_d        = 1'b0;
        w_d_prod   = '0;
        w_chg      = '0;
        w_chg_vld  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cancel) begin
                    w_coin_rej = c;
                    w_change   = r_credit;
                    w_credit   = '0;
                    w_chg      = r_credit;
                    w_chg_vld  = 1'b1;
                    w_state    = ST_CHG;
                end else if (sel_vld) begin
                    // Selection wins over a same-cycle coin and is judged on registered credit.
                    w_coin_rej = c;
                    if (w_sel_ok && (r_credit >= w_price)) begin
                        w_change = r_credit - w_price;
                        w_d      = 1'b1;
                        w_d_prod = sel;
                        w_state  = ST_DISP;
                    end else begin
                        w_nsf = 1'b1;
                    end
                end else if (c) begin
                    if (w_sum <= MAX_W) w_credit = w_sum[AMT_W-1:0];
                    else                w_coin_rej = 1'b1;
                end
            end
            ST_DISP: begin
                w_coin_rej = c;
                w_nsf      = sel_vld;
                w_credit   = '0;
                w_chg      = r_change;
                w_chg_vld  = 1'b1;
                w_state    = ST_CHG;
            end
            ST_CHG: begin
                w_coin_rej = c;
                w_nsf      = sel_vld;
                w_state    = ST_IDLE;
            end
            default: begin
                w_credit = '0;
                w_state  = ST_IDLE;
            end
        endcase
    end

    // Pulses are registered together with the state so d/chg_vld line up with DISP/CHG.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_change   <= '0;
            r_coin_rej <= 1'b0;
            r_nsf      <= 1'b0;
            r_d        <= 1'b0;
            r_d_prod   <= '0;
            r_chg      <= '0;
            r_chg_vld  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_credit   <= w_credit;
            r_change   <= w_change;
            r_coin_rej <= w_coin_rej;
            r_nsf      <= w_nsf;
            r_d        <= w_d;
            r_d_prod   <= w_d_prod;
            r_chg      <= w_chg;
            r_chg_vld  <= w_chg_vld;
        end
    end

    assign credit    = r_credit;
    assign busy      = (r_state != ST_IDLE);
    assign coin_rej  = r_coin_rej;
    assign nsf       = r_nsf;
    assign d         = r_d;
    assign d_prod    = r_d_prod;
    assign chg       = r_chg;
    assign chg_vld   = r_chg_vld;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Directed bench for vending_ctrl_multi: coin accumulation, vends, rejects, reset abort, cancel.
// Strobes (c, sel_vld, cancel) are sampled at posedge; outputs checked 1ns after it.
module tb_vending_ctrl_multi;
  logic        clk;
  logic        rst;
  logic        c;
  logic [7:0]  a;
  logic [31:0] s;
  logic [1:0]  sel;
  logic        sel_vld;
  logic        cancel;
  logic [7:0]  credit;
  logic        busy;
  logic        coin_rej;
  logic        nsf;
  logic        d;
  logic [1:0]  d_prod;
  logic [7:0]  chg;
  logic        chg_vld;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  vending_ctrl_multi dut (
    .clk(clk), .rst(rst), .c(c), .a(a), .s(s), .sel(sel), .sel_vld(sel_vld),
    .cancel(cancel), .credit(credit), .busy(busy), .coin_rej(coin_rej), .nsf(nsf),
    .d(d), .d_prod(d_prod), .chg(chg), .chg_vld(chg_vld), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic [7:0] v);
    c = 1'b1;
    a = v;
    tick();
    c = 1'b0;
    a = 8'd0;
  endtask

  task automatic select(input logic [1:0] k);
    sel = k;
    sel_vld = 1'b1;
    tick();
    sel_vld = 1'b0;
    sel = 2'd0;
  endtask

  initial begin
    rst = 1'b1; c = 1'b0; a = 8'd0; sel = 2'd0; sel_vld = 1'b0; cancel = 1'b0;
    s = {8'd50, 8'd200, 8'd65, 8'd150};
    #3;
    chk("rst_credit", credit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_d", d, 0);
    chk("rst_chg_vld", chg_vld, 0);
    chk("rst_state", dbg_state, 0);
    #9 rst = 1'b0;

    // Test 1: 150 credit buys product 0 at 150, change 0
    repeat (4) coin(8'd25);
    repeat (5) coin(8'd10);
    chk("t1_credit", credit, 150);
    select(2'd0);
    chk("t1_d", d, 1);
    chk("t1_dprod", d_prod, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_d_off", d, 0);
    chk("t1_chg_vld", chg_vld, 1);
    chk("t1_chg", chg, 0);
    chk("t1_credit0", credit, 0);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_chg_vld_off", chg_vld, 0);

    // Test 2: 200 credit buys product 2, then ceiling checks
    repeat (6) coin(8'd25);
    repeat (4) coin(8'd10);
    repeat (2) coin(8'd5);
    chk("t2_credit", credit, 200);
    select(2'd2);
    chk("t2_d", d, 1);
    chk("t2_dprod", d_prod, 2);
    tick();
    chk("t2_chg", chg, 0);
    chk("t2_chg_vld", chg_vld, 1);
    tick();
    coin(8'd100);
    coin(8'd100);
    chk("t2_credit200", credit, 200);
    coin(8'd100);
    chk("t2_coin_rej", coin_rej, 1);
    chk("t2_credit_kept", credit, 200);
    coin(8'd50);
    chk("t2_rej_clear", coin_rej, 0);
    chk("t2_credit_max", credit, 250);
    select(2'd2);
    tick();
    chk("t2_chg50", chg, 50);
    tick();

    // Test 3: change computation and insufficient funds
    coin(8'd100);
    select(2'd1);
    chk("t3_dprod", d_prod, 1);
    tick();
    chk("t3_chg", chg, 35);
    tick();
    coin(8'd25);
    select(2'd3);
    chk("t3_nsf", nsf, 1);
    chk("t3_no_d", d, 0);
    chk("t3_idle", busy, 0);
    tick();
    chk("t3_nsf_off", nsf, 0);
    chk("t3_credit", credit, 25);

    // Test 4: simultaneous coin+select, coin during DISP, select during CHG
    s[7:0] = 8'd50;
    coin(8'd50);
    chk("t4_credit", credit, 75);
    c = 1'b1; a = 8'd10; sel = 2'd0; sel_vld = 1'b1;
    tick();
    sel_vld = 1'b0; a = 8'd5;
    chk("t4_coin_rej", coin_rej, 1);
    chk("t4_d", d, 1);
    chk("t4_state_disp", dbg_state, 1);
    tick();
    c = 1'b0; a = 8'd0; sel_vld = 1'b1;
    chk("t4_disp_coin_rej", coin_rej, 1);
    chk("t4_chg", chg, 25);
    tick();
    sel_vld = 1'b0;
    chk("t4_chg_nsf", nsf, 1);
    chk("t4_credit0", credit, 0);
    chk("t4_idle", busy, 0);

    // Price 0 is accepted at zero credit
    s[15:8] = 8'd0;
    select(2'd1);
    chk("p0_d", d, 1);
    tick();
    chk("p0_chg_vld", chg_vld, 1);
    chk("p0_chg", chg, 0);
    tick();
    s[15:8] = 8'd65;

    // Test 5: reset mid-vend aborts with no change pulse
    coin(8'd25);
    coin(8'd25);
    select(2'd0);
    chk("t5_d", d, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_d", d, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_credit", credit, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("t5_no_chg", chg_vld, 0);
    chk("t5_credit", credit, 0);

    // Test 6: cancel with 40 credit
    coin(8'd25);
    coin(8'd10);
    coin(8'd5);
    chk("t6_credit", credit, 40);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t6_no_d", d, 0);
`ifdef VEND_CANCEL_EN
    chk("t6_chg_vld", chg_vld, 1);
    chk("t6_chg", chg, 40);
    chk("t6_credit", credit, 0);
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("t6_cancel0_ignored", chg_vld, 0);
`else
    chk("t6_chg_vld", chg_vld, 0);
    chk("t6_credit_kept", credit, 40);
    chk("t6_idle", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
